os_sa_core: RTL and testbench
=============================

Name: os_sa_core

Overview:
- Parametrised output-stationary systolic matrix-multiply core: C[ROWS][COLS] = sum over k of A[:,k]·B[k,:].
- Accepts one A column vector and one B row vector per beat over a valid/ready stream.
- Skews operands internally and accumulates in a ROWS×COLS grid of MAC PEs.
- Drains results one row per beat over a valid/ready result stream. Sits between the operand SRAM readers and the result writer.

Parameters:
- ROWS, 4, PE grid rows (A vector length).
- COLS, 4, PE grid columns (B vector length).
- DATA_WIDTH, 8, signed operand width.
- ACC_WIDTH, 24, signed accumulator width; must be ≥ 2*DATA_WIDTH.
- K_WIDTH, 8, width of the reduction-length field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- cfg_k_len  in  K_WIDTH  reduction length K, sampled with start
- busy  out  1  high in any state except IDLE
- op_valid  in  1  A/B beat valid
- op_ready  out  1  core accepts beat
- a_data  in  ROWS*DATA_WIDTH  A column; element i at bits [i*DW +: DW]
- b_data  in  COLS*DATA_WIDTH  B row; element j at bits [j*DW +: DW]
- res_valid  out  1  result row valid
- res_ready  in  1  downstream accepts row
- res_data  out  COLS*ACC_WIDTH  C row; column j at bits [j*ACC_WIDTH +: ACC_WIDTH]
- res_row  out  $clog2(ROWS)  row index of res_data
- res_last  out  1  final row of job
- done  out  1  one-cycle pulse after last row handshake

Behaviour:
- Clock and reset: clk, rst_n (asynchronous, active-low).
- Reset: FSM=IDLE; all accumulators, skew registers and valid tags =0; op_ready, res_valid, res_last, done, busy =0; res_data, res_row =0.
- Reset mid-job aborts immediately; no partial results are emitted.
- FSM IDLE→FEED on start. Start also clears all accumulators, latches K and zeroes the beat counter.
  - start with K=0 goes IDLE→DRAIN directly; an all-zero C is drained.
  - start while busy is ignored.
- FEED:
  - op_ready=1.
  - Each op_valid&op_ready handshake injects one beat and increments the beat counter.
  - op_valid low inserts a bubble: a valid tag of 0 travels with the operands, and PEs hold their accumulators.
  - After the K-th handshake: op_ready drops the next cycle; FEED→FLUSH.
- Skew: A element i is delayed i cycles before PE[i][0]; B element j is delayed j cycles before PE[0][j].
- Systolic flow: operands and the valid tag hop one PE per cycle, rightward for A and downward for B.
- PE[i][j] update: acc <= acc + sext(a)*sext(b) when its valid tag =1.
- FLUSH: a counter runs ROWS+COLS-1 cycles, covering the last operand reaching PE[ROWS-1][COLS-1] plus one register stage. Then FLUSH→DRAIN.
- DRAIN:
  - res_valid=1; res_row counts 0..ROWS-1; res_data = accumulators of that row.
  - res_last=1 on row ROWS-1.
  - res_ready low holds res_data, res_row and res_last stable.
  - On the last handshake: DRAIN→IDLE, done=1 for one cycle, res_valid=0.
- Arithmetic: products are 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH. Default overflow wraps modulo 2^ACC_WIDTH.

Optional Feature:
- OS_SAT_EN defined: each PE accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. A sticky output port sat_flag (1 bit) sets on any saturating update; it clears on start or reset.
- Not defined: wrap-around arithmetic, and the sat_flag port is absent.

Decomposition:
- Package os_sa_pkg holds:
  - FSM state enum (IDLE, FEED, FLUSH, DRAIN)
  - default width localparams
  - signed operand/accumulator typedefs
  - a saturating-add function used under OS_SAT_EN
- One sub-module, os_mac_pe:
  - registered a/b/valid forwarding
  - clear input
  - accumulator
  - optional saturation
- os_sa_core holds the FSM, counters, skew delay lines, PE generate grid and drain mux.

Test Plan:
- Identity: ROWS=COLS=4, K=4, A=I, B=[[1..4],[5..8],[9..12],[13..16]] → four rows equal to B, res_row 0..3, res_last on row 3, done pulse.
- Signed: K=1, a=all -128, b=all 127 → every C entry -16256; K=0 → four all-zero rows, no op_ready.
- Bubbles: K=3, all ones, op_valid toggled 1/0 → every C entry =3. op_ready drops after the 3rd handshake; extra beats are not accepted.
- Backpressure: res_ready held low 5 cycles in DRAIN → res_valid stays 1 and row 0 data stable; 4 rows delivered in order.
- Overflow: K=255, a=b=127, ACC_WIDTH=16 → wrapped value (255·16129 mod 2^16, signed) without macro; 32767 and sat_flag=1 with OS_SAT_EN.
- Reset mid-FEED after 2 beats → all outputs 0, IDLE. A new job with start runs correctly; start pulsed while busy has no effect.

Source files
------------

// File: rtl/os_sa_pkg.sv
// ---------------------------------------------------------------------------
// os_sa_pkg
// Shared definitions for the output-stationary systolic array core:
//   - FSM state enum (IDLE, FEED, FLUSH, DRAIN)
//   - default width localparams
//   - signed operand / accumulator typedefs at the default widths
//   - sat_add(): saturating add used when OS_SAT_EN is defined
// ---------------------------------------------------------------------------
package os_sa_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_K_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } sa_state_e;

  typedef logic signed [DEF_DATA_WIDTH-1:0] operand_t;
  typedef logic signed [DEF_ACC_WIDTH-1:0]  acc_t;

  // Adds two sign-extended values and clamps the sum to a signed w-bit range.
  // Callers pass operands already sign-extended to 64 bits; w must be <= 62
  // so the 64-bit sum itself can never overflow.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/os_mac_pe.sv
// ---------------------------------------------------------------------------
// os_mac_pe
// One multiply-accumulate processing element of the systolic grid.
// Operands and their valid tag are registered and forwarded (A rightward,
// B downward, tag travels with A). The accumulator adds the signed product of
// the incoming operands when the incoming tag is set; i_clr zeroes it.
// Optional build macro: OS_SAT_EN -> accumulate saturates, o_sat flags it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clr             synchronous accumulator clear (job start)
//   i_a, i_b, i_valid operands and valid tag from left / top neighbour
//   o_a, o_b, o_valid registered copies for right / bottom neighbour
//   o_acc             accumulator value
//   o_sat             (OS_SAT_EN only) this cycle's update saturated
// ---------------------------------------------------------------------------
module os_mac_pe
  import os_sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clr,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  input  logic                         i_valid,
  output logic signed [DATA_WIDTH-1:0] o_a,
  output logic signed [DATA_WIDTH-1:0] o_b,
  output logic                         o_valid,
  output logic signed [ACC_WIDTH-1:0]  o_acc
`ifdef OS_SAT_EN
  ,
  output logic                         o_sat
`endif
);

  logic signed [DATA_WIDTH-1:0]   r_a;
  logic signed [DATA_WIDTH-1:0]   r_b;
  logic                           r_valid;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [ACC_WIDTH-1:0]    w_acc_next;

  assign w_prod     = i_a * i_b;
  // Size cast of a signed value sign-extends.
  assign w_prod_ext = ACC_WIDTH'(w_prod);

`ifdef OS_SAT_EN
  logic signed [63:0] w_sum64;
  logic signed [63:0] w_sat_res;

  assign w_sum64    = 64'(r_acc) + 64'(w_prod_ext);
  assign w_sat_res  = sat_add(64'(r_acc), 64'(w_prod_ext), ACC_WIDTH);
  assign w_acc_next = w_sat_res[ACC_WIDTH-1:0];
  // Clamping happened exactly when the clamped value differs from the true sum.
  assign o_sat      = i_valid && !i_clr && (w_sat_res != w_sum64);
`else
  assign w_acc_next = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_valid <= i_valid;
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_valid) begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_valid = r_valid;
  assign o_acc   = r_acc;

endmodule

// File: rtl/os_sa_core.sv
// ---------------------------------------------------------------------------
// os_sa_core
// Output-stationary systolic matrix-multiply core: C = sum_k A[:,k] * B[k,:].
// One A column + one B row accepted per op handshake; operands are skewed
// (A row i by i cycles, B column j by j cycles) and flow through a
// ROWS x COLS grid of os_mac_pe. After K beats and a flush, C is drained one
// row per res handshake. ACC_WIDTH must be >= 2*DATA_WIDTH; ROWS, COLS >= 2.
// Optional build macro: OS_SAT_EN -> saturating accumulate plus sticky
// sat_flag output (cleared on start or reset).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, cfg_k_len           job start (IDLE only) and reduction length
//   busy                       state != IDLE
//   op_valid/op_ready          operand stream; a_data (A column), b_data (B row)
//   res_valid/res_ready        result stream; res_data row, res_row, res_last
//   done                       one-cycle pulse after the final row handshake
//   sat_flag                   (OS_SAT_EN only) sticky saturation indicator
// ---------------------------------------------------------------------------
module os_sa_core
  import os_sa_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [K_WIDTH-1:0]            cfg_k_len,
  output logic                          busy,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_data,
  input  logic [COLS*DATA_WIDTH-1:0]    b_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [COLS*ACC_WIDTH-1:0]     res_data,
  output logic [$clog2(ROWS)-1:0]       res_row,
  output logic                          res_last,
  output logic                          done
`ifdef OS_SAT_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int ROW_W     = $clog2(ROWS);
  // Last operand needs ROWS-1 + COLS-1 hops plus the capture register stage.
  localparam int FLUSH_CYC = ROWS + COLS - 1;
  localparam int FLUSH_W   = $clog2(FLUSH_CYC);

  sa_state_e            r_state;
  logic [K_WIDTH-1:0]   r_k;
  logic [K_WIDTH-1:0]   r_beat;
  logic [FLUSH_W-1:0]   r_flush;
  logic [ROW_W-1:0]     r_row;
  logic                 r_done;

  logic                 w_start;
  logic                 w_beat_hs;
  logic                 w_last_row;

  // Grid interconnect: w_a/w_v[i][j] and w_b[i][j] are the inputs of PE[i][j];
  // the extra column/row collects the outputs of the edge PEs.
  logic signed [DATA_WIDTH-1:0] w_a   [ROWS][COLS+1];
  logic                         w_v   [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0] w_b   [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0]  w_acc [ROWS][COLS];

  assign w_start    = start && (r_state == IDLE);
  assign w_beat_hs  = op_valid && (r_state == FEED);
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k     <= cfg_k_len;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
            r_state <= (cfg_k_len == '0) ? DRAIN : FEED;
          end
        end
        FEED: begin
          if (op_valid) begin
            r_beat <= r_beat + 1'b1;
            if ((r_beat + 1'b1) == r_k) begin
              r_flush <= '0;
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (r_flush == FLUSH_W'(FLUSH_CYC - 1)) begin
            r_state <= DRAIN;
          end else begin
            r_flush <= r_flush + 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (w_last_row) begin
              r_row   <= '0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- skew
  // Stage 0 captures the beat; each row/column then waits gi more cycles.
  // Data is captured every cycle, only the tag marks real beats.
  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
      logic signed [DATA_WIDTH-1:0] r_a_dly [gi+1];
      logic                         r_v_dly [gi+1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s <= gi; s++) begin
            r_a_dly[s] <= '0;
            r_v_dly[s] <= 1'b0;
          end
        end else begin
          r_a_dly[0] <= a_data[gi*DATA_WIDTH +: DATA_WIDTH];
          r_v_dly[0] <= w_beat_hs;
          for (int s = 1; s <= gi; s++) begin
            r_a_dly[s] <= r_a_dly[s-1];
            r_v_dly[s] <= r_v_dly[s-1];
          end
        end
      end
      assign w_a[gi][0] = r_a_dly[gi];
      assign w_v[gi][0] = r_v_dly[gi];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
      logic signed [DATA_WIDTH-1:0] r_b_dly [gi+1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s <= gi; s++) begin
            r_b_dly[s] <= '0;
          end
        end else begin
          r_b_dly[0] <= b_data[gi*DATA_WIDTH +: DATA_WIDTH];
          for (int s = 1; s <= gi; s++) begin
            r_b_dly[s] <= r_b_dly[s-1];
          end
        end
      end
      assign w_b[0][gi] = r_b_dly[gi];
    end
  endgenerate

  // ---------------------------------------------------------------- PE grid
`ifdef OS_SAT_EN
  logic w_sat_hit [ROWS][COLS];
`endif

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        os_mac_pe #(
          .DATA_WIDTH (DATA_WIDTH),
          .ACC_WIDTH  (ACC_WIDTH)
        ) u_pe (
          .clk     (clk),
          .rst_n   (rst_n),
          .i_clr   (w_start),
          .i_a     (w_a[gi][gj]),
          .i_b     (w_b[gi][gj]),
          .i_valid (w_v[gi][gj]),
          .o_a     (w_a[gi][gj+1]),
          .o_b     (w_b[gi+1][gj]),
          .o_valid (w_v[gi][gj+1]),
          .o_acc   (w_acc[gi][gj])
`ifdef OS_SAT_EN
          ,
          .o_sat   (w_sat_hit[gi][gj])
`endif
        );
      end
    end
  endgenerate

`ifdef OS_SAT_EN
  logic w_any_sat;
  logic r_sat_flag;

  always_comb begin
    w_any_sat = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        w_any_sat = w_any_sat | w_sat_hit[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
    end else if (w_start) begin
      r_sat_flag <= 1'b0;
    end else if (w_any_sat) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
`endif

  // ---------------------------------------------------------------- drain mux
  // Accumulators are frozen in DRAIN, so the selected row is stable while
  // res_ready is low.
  generate
    for (gj = 0; gj < COLS; gj++) begin : g_drain
      assign res_data[gj*ACC_WIDTH +: ACC_WIDTH] =
        (r_state == DRAIN) ? w_acc[r_row][gj] : '0;
    end
  endgenerate

  assign busy      = (r_state != IDLE);
  assign op_ready  = (r_state == FEED);
  assign res_valid = (r_state == DRAIN);
  assign res_row   = r_row;
  assign res_last  = (r_state == DRAIN) && w_last_row;
  assign done      = r_done;

endmodule

// File: tb/tb_os_sa_core.sv
`timescale 1ns/1ps
module tb_os_sa_core;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KW   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [KW-1:0]        cfg_k_len;
  logic                 busy;
  logic                 op_valid;
  logic                 op_ready;
  logic [ROWS*DW-1:0]   a_data;
  logic [COLS*DW-1:0]   b_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [COLS*AW-1:0]   res_data;
  logic [1:0]           res_row;
  logic                 res_last;
  logic                 done;
`ifdef OS_SAT_EN
  logic                 sat_flag;
`endif

  always #5 clk = ~clk;

  os_sa_core #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k_len(cfg_k_len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .a_data(a_data), .b_data(b_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_last(res_last), .done(done)
`ifdef OS_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Operand matrices by beat: mat_a[k][i] = A[i][k], mat_b[k][j] = B[k][j].
  logic signed [DW-1:0] mat_a [256][ROWS];
  logic signed [DW-1:0] mat_b [256][COLS];
  longint               exp_c [ROWS][COLS];
  bit                   exp_sat;

  typedef struct {
    int     k;
    int     av;
    int     bv;
    int     bubble;
    int     bp;
    longint exp_v;
    bit     exp_s;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [ROWS*DW-1:0] pack_a(input int idx);
    logic [ROWS*DW-1:0] p;
    p = '0;
    for (int i = 0; i < ROWS; i++) p[i*DW +: DW] = mat_a[idx][i];
    return p;
  endfunction

  function automatic logic [COLS*DW-1:0] pack_b(input int idx);
    logic [COLS*DW-1:0] p;
    p = '0;
    for (int j = 0; j < COLS; j++) p[j*DW +: DW] = mat_b[idx][j];
    return p;
  endfunction

  // Reference: plain dot products, wrapped to AW bits or clamped per step.
  task automatic model(input int k);
    longint m;
    longint maxv;
    longint minv;
    m    = longint'(1) <<< AW;
    maxv = (m / 2) - 1;
    minv = -(m / 2);
    exp_sat = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        longint acc;
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc = acc + longint'(mat_a[kk][i]) * longint'(mat_b[kk][j]);
`ifdef OS_SAT_EN
          if (acc > maxv) begin acc = maxv; exp_sat = 1'b1; end
          else if (acc < minv) begin acc = minv; exp_sat = 1'b1; end
`else
          acc = acc & (m - 1);
          if (acc > maxv) acc = acc - m;
`endif
        end
        exp_c[i][j] = acc;
      end
    end
  endtask

  // bubble: 0 none, 1 toggle 1/0, 2 random. bp: cycles res_ready held low on row 0.
  task automatic run_job(input int k, input int bubble, input int bp, input bit busy_start);
    int sent;
    int cyc;
    bit v;
    bit seen;
    bit stable;
    logic [COLS*AW-1:0] first;
    logic [COLS*AW-1:0] exp_row;
    @(negedge clk);
    start = 1'b1; cfg_k_len = KW'(k);
    @(negedge clk);
    start = 1'b0; cfg_k_len = '0;
    chk("busy_after_start", busy, 1);
    sent = 0; cyc = 0;
    while (sent < k && cyc < 5000) begin
      case (bubble)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      op_valid = v; a_data = pack_a(sent); b_data = pack_b(sent);
      if (busy_start && sent == 1) begin start = 1'b1; cfg_k_len = 8'd7; end
      else begin start = 1'b0; cfg_k_len = '0; end
      if (v && op_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; cfg_k_len = '0;
    chk("beats_accepted", sent, k);
    // Junk beats offered after K must be refused.
    op_valid = 1'b1; a_data = $urandom; b_data = $urandom;
    cyc = 0; seen = 1'b0;
    while (!res_valid && cyc < 200) begin
      seen |= op_ready;
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0;
    chk("res_valid_seen", res_valid, 1);
    chk("no_op_ready_after_feed", seen, 0);
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0 && bp > 0) begin
        res_ready = 1'b0; first = res_data; stable = 1'b1;
        for (int c = 0; c < bp; c++) begin
          @(negedge clk);
          stable &= res_valid && (res_data == first) && (res_row == 2'd0);
        end
        chk("backpressure_hold", stable, 1);
      end
      for (int j = 0; j < COLS; j++) begin
        longint e;
        e = exp_c[r][j];
        exp_row[j*AW +: AW] = e[AW-1:0];
      end
      chk("row_valid", res_valid, 1);
      chk("res_row", res_row, r);
      chk("res_last", res_last, (r == ROWS - 1));
      chk("res_data", res_data, exp_row);
      $display("row %0d data=%h last=%0d", res_row, res_data, res_last);
      res_ready = 1'b1;
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("res_valid_after_drain", res_valid, 0);
    chk("busy_after_drain", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
`ifdef OS_SAT_EN
    chk("sat_flag", sat_flag, exp_sat);
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_ready"}, op_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_row_last_done"}, {res_row, res_last, done}, 0);
`ifdef OS_SAT_EN
    chk({tag, "_sat_flag"}, sat_flag, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_k_len = '0; op_valid = 1'b0;
    a_data = '0; b_data = '0; res_ready = 1'b0;

    vecs[0] = '{k: 1,   av: -128, bv: 127, bubble: 0, bp: 0, exp_v: -16256, exp_s: 1'b0};
    vecs[1] = '{k: 0,   av: 0,    bv: 0,   bubble: 0, bp: 0, exp_v: 0,      exp_s: 1'b0};
    vecs[2] = '{k: 3,   av: 1,    bv: 1,   bubble: 1, bp: 0, exp_v: 3,      exp_s: 1'b0};
    vecs[3] = '{k: 2,   av: 5,    bv: -3,  bubble: 0, bp: 5, exp_v: -30,    exp_s: 1'b0};
`ifdef OS_SAT_EN
    vecs[4] = '{k: 255, av: 127,  bv: 127, bubble: 0, bp: 0, exp_v: 32767,  exp_s: 1'b1};
`else
    // 255*16129 = 4112895; mod 65536 = 49663 -> signed -15873
    vecs[4] = '{k: 255, av: 127,  bv: 127, bubble: 0, bp: 0, exp_v: -15873, exp_s: 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Identity A times B = B.
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < ROWS; i++) mat_a[kk][i] = (i == kk) ? 8'sd1 : 8'sd0;
      for (int j = 0; j < COLS; j++) mat_b[kk][j] = DW'(kk * 4 + j + 1);
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) exp_c[i][j] = i * 4 + j + 1;
    exp_sat = 1'b0;
    run_job(4, 0, 0, 1'b0);

    // Uniform-matrix vector table.
    for (int t = 0; t < 5; t++) begin
      for (int kk = 0; kk < vecs[t].k; kk++) begin
        for (int i = 0; i < ROWS; i++) mat_a[kk][i] = DW'(vecs[t].av);
        for (int j = 0; j < COLS; j++) mat_b[kk][j] = DW'(vecs[t].bv);
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) exp_c[i][j] = vecs[t].exp_v;
      exp_sat = vecs[t].exp_s;
      run_job(vecs[t].k, vecs[t].bubble, vecs[t].bp, 1'b0);
    end

    // start pulsed while busy must be ignored.
    for (int kk = 0; kk < 3; kk++) begin
      for (int i = 0; i < ROWS; i++) mat_a[kk][i] = DW'($urandom_range(0, 20));
      for (int j = 0; j < COLS; j++) mat_b[kk][j] = DW'($urandom_range(0, 20));
    end
    model(3);
    run_job(3, 0, 0, 1'b1);

    // Reset in the middle of FEED after two beats.
    @(negedge clk);
    start = 1'b1; cfg_k_len = 8'd4;
    @(negedge clk);
    start = 1'b0; cfg_k_len = '0;
    op_valid = 1'b1; a_data = 32'h7f7f7f7f; b_data = 32'h7f7f7f7f;
    @(negedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_midreset", busy, 0);

    // Randomised jobs against the reference model.
    for (int n = 0; n < 7; n++) begin
      int k;
      k = $urandom_range(1, 10);
      for (int kk = 0; kk < k; kk++) begin
        for (int i = 0; i < ROWS; i++) mat_a[kk][i] = DW'($urandom);
        for (int j = 0; j < COLS; j++) mat_b[kk][j] = DW'($urandom);
      end
      model(k);
      run_job(k, 2, $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
